controle_rodadas: RTL and testbench
===================================

# controle_rodadas

Round-sequencing control unit for the memory-game datapath: counter-addressed sync ROM, play register, 4-bit comparator, play edge detector. Drives a progressive game. Round *k* requires the player to reproduce ROM entries 0..k in order, and each play has a bounded wait. Replaces the single-pass control unit; a round counter and an address-vs-round comparator are added to the datapath.

## Interface
Parameters:
- TIMEOUT, 5000: max cycles spent in espera_jogada per play before timeout (≥2).
- TW, 13: timer width, ≥ clog2(TIMEOUT).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clock.
- iniciar  in  1  start/restart request (level).
- jogada  in  1  one-cycle pulse from play edge detector.
- igual  in  1  comparator: ROM data == registered play.
- enderecoIgualRodada  in  1  address counter == round counter.
- fimRodada  in  1  round counter at last value.
- zeraE, contaE  out  1  clear / increment address counter.
- zeraRod, contaRod  out  1  clear / increment round counter.
- zeraJ, registraJ  out  1  clear / load play register.
- acertou, errou, timeout, pronto  out  1  game result flags.
- db_estado  out  4  current state code.

## Operation
- Moore FSM. Outputs are decoded from the state register only. State codes are hex, also driven on db_estado:
- 0 inicial: zeraE, zeraRod, zeraJ = 1. iniciar → 1.
- 1 preparacao: zeraE, zeraRod, zeraJ = 1. → 2.
- 2 inicia_rodada: zeraE = 1. → 3.
- 3 espera_jogada: timer runs. jogada → 4; else timer == TIMEOUT-1 → D; else stay.
- 4 registra: registraJ = 1. → 5.
- 5 comparacao: !igual → E; igual & enderecoIgualRodada & fimRodada → A; igual & enderecoIgualRodada & !fimRodada → 8; igual & !enderecoIgualRodada → 6.
- 6 proxima_jogada: contaE = 1. → 3.
- 8 proxima_rodada: contaRod = 1, zeraJ = 1. → 2.
- A fim_acerto: acertou = pronto = 1.
- E fim_erro: errou = pronto = 1.
- D fim_timeout: timeout = errou = pronto = 1.
- States A, E and D all go to 1 on iniciar; otherwise they hold.
- Unused codes → 0, with db_estado = F for one cycle.
- Timer:
  - TW-bit counter, increments only while in state 3.
  - Cleared on every cycle outside state 3, so each play gets a fresh budget.
  - No wrap; the expiry compare is exact equality.
- Simultaneous jogada and expiry in state 3: jogada wins (→ 4).
- jogada pulses outside state 3 are ignored, not queued.
- iniciar is ignored in states 1–8.

## Timing
- Reset: while reset = 0 at a rising edge, state ← 0 and timer ← 0, regardless of iniciar or jogada.
  - The next cycle shows the inicial outputs: zeraE = zeraRod = zeraJ = 1, all other outputs 0, db_estado = 0.
  - Applies mid-game in every state, including mid-timeout.
- Latency:
  - iniciar sampled in state 0 → state 3 reached two edges later.
  - jogada sampled → registraJ the next cycle → comparison one cycle after that. The play register is loaded at the edge leaving state 4, so igual is valid in state 5.
- Sync ROM: the address changes at the edge leaving 6 or 2. State 3 lasts ≥1 cycle, so ROM data settles before state 5.
  - This ≥2-cycle margin between address change and comparison is a requirement on the FSM path.
- Timeout: entering 3 at edge t0 with no jogada → state D at edge t0 + TIMEOUT.
- Outputs are glitch-free: state is registered, with no input-to-output combinational path.

## Structure
- Shared package `jogo_pkg`:
  - 4-bit state code constants (0,1,2,3,4,5,6,8,A,E,D,F).
  - Default TIMEOUT.
  - These are also used by testbench decoders and hexa7seg debug wiring.
- One sub-module, `contador_timeout`:
  - Ports: clock, reset, conta, zera (synchronous), fim.
  - fim = (count == TIMEOUT-1). Instantiated once in the FSM.
- Round counter and address comparator live in the datapath, not here.

## Test plan
- Reset: reset = 0 for 2 cycles with iniciar = 1 → db_estado = 0, zeraE = zeraRod = zeraJ = 1, other outputs 0. Release, iniciar pulse → db_estado 1, 2, 3 on successive cycles.
- Full win, datapath with 4 rounds, ROM 1,2,4,8: correct plays 1 | 1,2 | 1,2,4 | 1,2,4,8 → states cycle 3→4→5→6/8 as specified; ends in A, acertou = pronto = 1, errou = 0.
- Error: in round 2, plays 1 then 4 → state E at the second comparison, errou = pronto = 1, contaRod never asserted after round 2.
- Timeout, TIMEOUT = 8: enter state 3, no jogada → state D exactly 8 cycles after entry, timeout = errou = pronto = 1.
- Race, TIMEOUT = 8: jogada on the expiry cycle → state 4, not D. Timer is back to 0 on the next entry to 3.
- Restart and mid-game reset:
  - iniciar from A, E and D → 1, with zeraRod = 1.
  - reset = 0 during state 6 → state 0 at the next edge, timer cleared.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game control: state codes and default play timeout.
package jogo_pkg;

  localparam int TIMEOUT_PADRAO = 5000;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMA_JOGADA = 4'h6,
    PROXIMA_RODADA = 4'h8,
    FIM_ACERTO     = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

  // Shown on db_estado for one cycle when the state register holds an unused code.
  localparam logic [3:0] ST_INVALIDO = 4'hF;

endpackage

// File: rtl/contador_timeout.sv
// Per-play wait timer: counts while enabled, cleared synchronously, flags the last allowed cycle.
module contador_timeout
  import jogo_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_PADRAO,
  parameter int TW      = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic conta,
  input  logic zera,
  output logic fim
);

  logic [TW-1:0] cont_q, cont_d;

  // Next count: clear has priority; no wrap is needed since the FSM leaves on fim.
  always_comb begin
    cont_d = cont_q;
    if (zera) begin
      cont_d = '0;
    end else if (conta) begin
      cont_d = cont_q + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      cont_d = cont_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign fim = (cont_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/controle_rodadas.sv
// Moore control unit for the progressive memory game: round k replays ROM entries 0..k,
// each play bounded by a wait timer.
module controle_rodadas
  import jogo_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_PADRAO,
  parameter int TW      = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       fimRodada,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraRod,
  output logic       contaRod,
  output logic       zeraJ,
  output logic       registraJ,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t estado_q, estado_d;
  logic    em_espera_s;
  logic    zera_timer_s;
  logic    fim_timer_s;

  // Timer only runs in espera_jogada, so each play starts with a fresh budget.
  assign em_espera_s  = (estado_q == ESPERA_JOGADA);
  assign zera_timer_s = ~em_espera_s;

  contador_timeout #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .conta (em_espera_s),
    .zera  (zera_timer_s),
    .fim   (fim_timer_s)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state and Moore output decode from the state register alone.
  always_comb begin
    estado_d  = estado_q;
    db_estado = estado_q;
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraRod   = 1'b0;
    contaRod  = 1'b0;
    zeraJ     = 1'b0;
    registraJ = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    pronto    = 1'b0;
    case (estado_q)
      INICIAL: begin
        zeraE   = 1'b1;
        zeraRod = 1'b1;
        zeraJ   = 1'b1;
        estado_d = iniciar ? PREPARACAO : INICIAL;
      end
      PREPARACAO: begin
        zeraE    = 1'b1;
        zeraRod  = 1'b1;
        zeraJ    = 1'b1;
        estado_d = INICIA_RODADA;
      end
      INICIA_RODADA: begin
        zeraE    = 1'b1;
        estado_d = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        // A play arriving on the expiry cycle still counts.
        if (jogada) begin
          estado_d = REGISTRA;
        end else if (fim_timer_s) begin
          estado_d = FIM_TIMEOUT;
        end else begin
          estado_d = ESPERA_JOGADA;
        end
      end
      REGISTRA: begin
        registraJ = 1'b1;
        estado_d  = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual) begin
          estado_d = FIM_ERRO;
        end else if (!enderecoIgualRodada) begin
          estado_d = PROXIMA_JOGADA;
        end else if (fimRodada) begin
          estado_d = FIM_ACERTO;
        end else begin
          estado_d = PROXIMA_RODADA;
        end
      end
      PROXIMA_JOGADA: begin
        contaE   = 1'b1;
        estado_d = ESPERA_JOGADA;
      end
      PROXIMA_RODADA: begin
        contaRod = 1'b1;
        zeraJ    = 1'b1;
        estado_d = INICIA_RODADA;
      end
      FIM_ACERTO: begin
        acertou  = 1'b1;
        pronto   = 1'b1;
        estado_d = iniciar ? PREPARACAO : FIM_ACERTO;
      end
      FIM_ERRO: begin
        errou    = 1'b1;
        pronto   = 1'b1;
        estado_d = iniciar ? PREPARACAO : FIM_ERRO;
      end
      FIM_TIMEOUT: begin
        timeout  = 1'b1;
        errou    = 1'b1;
        pronto   = 1'b1;
        estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
      end
      default: begin
        db_estado = ST_INVALIDO;
        estado_d  = INICIAL;
      end
    endcase
  end

endmodule

// File: tb/tb_controle_rodadas.sv
// Bench for controle_rodadas: a behavioural datapath (sync ROM 1,2,4,8, four rounds) plus a
// game-level model predicting the state sequence of every play.
module tb_controle_rodadas;

  localparam int TO = 8;

  logic       clock, reset, iniciar, jogada;
  logic       igual, enderecoIgualRodada, fimRodada;
  logic       zeraE, contaE, zeraRod, contaRod, zeraJ, registraJ;
  logic       acertou, errou, timeout, pronto;
  logic [3:0] db_estado;
  logic [9:0] outs;

  logic [3:0] botoes;
  logic [1:0] end_q, rod_q;
  logic [3:0] jog_q, rom_q;
  logic [3:0] rom_dp [0:3];

  int checks = 0;
  int passes = 0;

  controle_rodadas #(.TIMEOUT(TO), .TW(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .enderecoIgualRodada(enderecoIgualRodada), .fimRodada(fimRodada),
    .zeraE(zeraE), .contaE(contaE), .zeraRod(zeraRod), .contaRod(contaRod),
    .zeraJ(zeraJ), .registraJ(registraJ), .acertou(acertou), .errou(errou),
    .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign outs = {zeraE, contaE, zeraRod, contaRod, zeraJ, registraJ, acertou, errou, timeout, pronto};

  // Environment datapath: address/round counters, play register and sync ROM.
  initial begin
    rom_dp[0] = 4'd1; rom_dp[1] = 4'd2; rom_dp[2] = 4'd4; rom_dp[3] = 4'd8;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      end_q <= 2'd0; rod_q <= 2'd0; jog_q <= 4'd0; rom_q <= 4'd0;
    end else begin
      if (zeraE) end_q <= 2'd0; else if (contaE) end_q <= end_q + 2'd1;
      if (zeraRod) rod_q <= 2'd0; else if (contaRod) rod_q <= rod_q + 2'd1;
      if (zeraJ) jog_q <= 4'd0; else if (registraJ) jog_q <= botoes;
      rom_q <= rom_dp[end_q];
    end
  end
  assign igual               = (rom_q == jog_q);
  assign enderecoIgualRodada = (end_q == rod_q);
  assign fimRodada           = (rod_q == 2'd3);

  // Output table of each state, order {zeraE,contaE,zeraRod,contaRod,zeraJ,registraJ,acertou,errou,timeout,pronto}.
  function automatic logic [9:0] exp_outs(input logic [3:0] s);
    case (s)
      4'h0, 4'h1: return 10'b1010100000;
      4'h2:       return 10'b1000000000;
      4'h4:       return 10'b0000010000;
      4'h6:       return 10'b0100000000;
      4'h8:       return 10'b0001100000;
      4'hA:       return 10'b0000001001;
      4'hE:       return 10'b0000000101;
      4'hD:       return 10'b0000000111;
      default:    return 10'b0000000000;
    endcase
  endfunction

  function automatic logic [3:0] seq_val(input int j);
    logic [3:0] one;
    one = 4'd1;
    return one << j;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pulse iniciar from state 0 or a terminal state; expect 1, 2, 3 with noise on ignored inputs.
  task automatic start_game();
    logic [13:0] got, want;
    iniciar = 1'b1; jogada = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      got = {db_estado, outs}; want = {i[3:0], exp_outs(i[3:0])};
      checks++;
      if (got !== want) $display("FAIL start_%0d: got %h/%b expected %h/%b", i, got[13:10], got[9:0], want[13:10], want[9:0]);
      else passes++;
      if (i < 3) begin iniciar = 1'($urandom % 2); jogada = 1'($urandom % 2); end
    end
    iniciar = 1'b0; jogada = 1'b0;
  endtask

  // One play of round k, position j: wait d cycles in state 3, then play val (d >= TO: no play).
  // res: 0 game continues, 1 win, 2 error, 3 timeout. Ends sampled in the next state 3 or a terminal.
  task automatic do_play(input logic [3:0] val, input int d, input int k, input int j, output int res);
    logic [13:0] got, want;
    logic [3:0]  nxt [$];
    nxt = {};
    res = 0;
    for (int i = 0; i < d && i < TO; i++) begin
      got = {db_estado, outs}; want = {4'h3, exp_outs(4'h3)};
      checks++;
      if (got !== want) $display("FAIL espera k%0d j%0d i%0d: got %h/%b expected %h/%b", k, j, i, got[13:10], got[9:0], want[13:10], want[9:0]);
      else passes++;
      step();
    end
    if (d >= TO) begin
      nxt.push_back(4'hD);
      res = 3;
    end else begin
      got = {db_estado, outs}; want = {4'h3, exp_outs(4'h3)};
      checks++;
      if (got !== want) $display("FAIL pre_jogada k%0d j%0d: got %h/%b expected %h/%b", k, j, got[13:10], got[9:0], want[13:10], want[9:0]);
      else passes++;
      botoes = val; jogada = 1'b1;
      nxt.push_back(4'h4); nxt.push_back(4'h5);
      if (val != seq_val(j)) begin nxt.push_back(4'hE); res = 2; end
      else if (j != k) begin nxt.push_back(4'h6); nxt.push_back(4'h3); end
      else if (k == 3) begin nxt.push_back(4'hA); res = 1; end
      else begin nxt.push_back(4'h8); nxt.push_back(4'h2); nxt.push_back(4'h3); end
    end
    foreach (nxt[n]) begin
      step();
      if (nxt[n] == 4'h5) botoes = 4'($urandom);
      if (nxt[n] == 4'h4 || nxt[n] == 4'h5) begin
        jogada = 1'($urandom % 2); iniciar = 1'($urandom % 2);
      end else begin
        jogada = 1'b0; iniciar = 1'b0;
      end
      got = {db_estado, outs}; want = {nxt[n], exp_outs(nxt[n])};
      checks++;
      if (got !== want) $display("FAIL play k%0d j%0d s%0d: got %h/%b expected %h/%b", k, j, n, got[13:10], got[9:0], want[13:10], want[9:0]);
      else passes++;
    end
    jogada = 1'b0; iniciar = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] got, want;
    reset = 1'b0; iniciar = 1'b1; jogada = 1'b1; botoes = 4'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      got = {db_estado, outs}; want = {4'h0, exp_outs(4'h0)};
      checks++;
      if (got !== want) $display("FAIL reset_%0d: got %h/%b expected %h/%b", i, got[13:10], got[9:0], want[13:10], want[9:0]);
      else passes++;
    end
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0;
    step();
    got = {db_estado, outs}; want = {4'h0, exp_outs(4'h0)};
    checks++;
    if (got !== want) $display("FAIL idle: got %h/%b expected %h/%b", got[13:10], got[9:0], want[13:10], want[9:0]);
    else passes++;
  endtask

  task automatic test_win();
    int res;
    logic [13:0] got, want;
    start_game();
    res = 0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j <= k; j++)
        do_play(seq_val(j), int'($urandom_range(0, 3)), k, j, res);
    jogada = 1'b1;
    step(); step();
    jogada = 1'b0;
    got = {db_estado, outs}; want = {4'hA, exp_outs(4'hA)};
    checks++;
    if (got !== want || res != 1) $display("FAIL win_hold: got %h/%b res %0d expected %h/%b res 1", got[13:10], got[9:0], res, want[13:10], want[9:0]);
    else passes++;
  endtask

  task automatic test_error();
    int res;
    logic [13:0] got, want;
    start_game();
    do_play(4'd1, 1, 0, 0, res);
    do_play(4'd1, 0, 1, 0, res);
    do_play(4'd2, 2, 1, 1, res);
    do_play(4'd1, 1, 2, 0, res);
    do_play(4'd4, 0, 2, 1, res);
    for (int i = 0; i < 3; i++) begin
      step();
      got = {db_estado, outs}; want = {4'hE, exp_outs(4'hE)};
      checks++;
      if (got !== want) $display("FAIL erro_hold_%0d: got %h/%b expected %h/%b", i, got[13:10], got[9:0], want[13:10], want[9:0]);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    int res;
    start_game();
    do_play(4'd1, TO, 0, 0, res);
  endtask

  task automatic test_race();
    int res;
    start_game();
    do_play(4'd1, TO - 1, 0, 0, res);
    do_play(4'd1, TO - 1, 1, 0, res);
    do_play(4'd2, TO - 1, 1, 1, res);
    do_play(4'd3, 0, 2, 0, res);
  endtask

  task automatic test_midgame_reset();
    int res;
    logic [13:0] got, want;
    start_game();
    do_play(4'd1, 0, 0, 0, res);
    botoes = 4'd1; jogada = 1'b1;
    step(); jogada = 1'b0;
    step(); step();
    got = {db_estado, outs}; want = {4'h6, exp_outs(4'h6)};
    checks++;
    if (got !== want) $display("FAIL antes_reset: got %h/%b expected %h/%b", got[13:10], got[9:0], want[13:10], want[9:0]);
    else passes++;
    reset = 1'b0;
    step();
    reset = 1'b1;
    got = {db_estado, outs}; want = {4'h0, exp_outs(4'h0)};
    checks++;
    if (got !== want) $display("FAIL reset_em_6: got %h/%b expected %h/%b", got[13:10], got[9:0], want[13:10], want[9:0]);
    else passes++;
    start_game();
    for (int i = 0; i < 5; i++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    got = {db_estado, outs}; want = {4'h0, exp_outs(4'h0)};
    checks++;
    if (got !== want) $display("FAIL reset_em_espera: got %h/%b expected %h/%b", got[13:10], got[9:0], want[13:10], want[9:0]);
    else passes++;
    start_game();
    do_play(4'd1, TO - 1, 0, 0, res);
    do_play(4'd9, 0, 1, 0, res);
  endtask

  task automatic test_random();
    int res, d;
    logic [3:0] val;
    for (int g = 0; g < 20; g++) begin
      start_game();
      res = 0;
      for (int k = 0; k < 4 && res == 0; k++)
        for (int j = 0; j <= k && res == 0; j++) begin
          val = seq_val(j);
          if ($urandom % 10 == 0) val = val ^ 4'($urandom_range(1, 15));
          d = ($urandom % 12 == 0) ? TO : int'($urandom_range(0, TO - 1));
          do_play(val, d, k, j, res);
        end
    end
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; botoes = 4'd0;
    test_reset();
    test_win();
    test_error();
    test_timeout();
    test_race();
    test_midgame_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
